// File: rtl/boot_rom_arbiter_if.sv
// Bus bundle between the instruction/data requesters, boot_rom_arbiter and the boot ROM macro.
// Port names carry the arbiter's point of view (_i into the arbiter, _o out of it).
interface boot_rom_arbiter_if #(
  parameter int ROM_AW = 10
);
  // Handshake: a requester raises req with a stable addr (and we) and holds both
  // until gnt is seen high in the same cycle; exactly one cycle after that gnt the
  // port sees rvalid=1 with rdata/err. err is meaningful only while rvalid=1.
  logic              instr_req_i;
  logic [31:0]       instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [31:0]       instr_rdata_o;
  logic              instr_err_o;

  logic              data_req_i;
  logic [31:0]       data_addr_i;
  logic              data_we_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [31:0]       data_rdata_o;
  logic              data_err_o;

  logic              rom_csn_o;
  logic [ROM_AW-1:0] rom_a_o;
  logic [31:0]       rom_q_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_addr_i, data_we_i,
    input  rom_q_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output rom_csn_o, rom_a_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_addr_i, data_we_i,
    output rom_q_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  rom_csn_o, rom_a_o
  );
endinterface

// File: rtl/boot_rom_arbiter.sv
// Two-port arbiter in front of the single-read-port boot ROM (instr fetch vs debug/data).
// Define BOOT_ROM_ARB_RR_EN for round-robin contention; otherwise instr has fixed priority.
module boot_rom_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
  parameter int          ROM_WORDS = 548,
  parameter int          ROM_AW    = 10
) (
  input  logic                CLK,
  input  logic                RSTN,
  boot_rom_arbiter_if.slave   bus,
  output logic [3:0]          dbg_state
);

  localparam logic [31:0] ROM_BYTES   = 32'(ROM_WORDS * 4);
  localparam logic        OWNER_INSTR = 1'b0;
  localparam logic        OWNER_DATA  = 1'b1;
  localparam logic        PRIO_INSTR  = 1'b0;

  typedef struct packed {
    logic valid;
    logic owner;
    logic err;
    logic prio;
  } resp_state_t;

  resp_state_t state_q;
  resp_state_t state_d;

  logic [31:0]       instr_off;
  logic [31:0]       data_off;
  logic              instr_bad;
  logic              data_bad;
  logic [ROM_AW-1:0] instr_word;
  logic [ROM_AW-1:0] data_word;
  logic              grant_instr;
  logic              grant_data;
  logic [31:0]       resp_rdata;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range naturally.
  assign instr_off  = bus.instr_addr_i - BASE_ADDR;
  assign data_off   = bus.data_addr_i - BASE_ADDR;
  assign instr_bad  = (instr_off >= ROM_BYTES) || (bus.instr_addr_i[1:0] != 2'b00);
  assign data_bad   = (data_off >= ROM_BYTES) || (bus.data_addr_i[1:0] != 2'b00) ||
                      bus.data_we_i;
  assign instr_word = instr_off[ROM_AW+1:2];
  assign data_word  = data_off[ROM_AW+1:2];

`ifdef BOOT_ROM_ARB_RR_EN
  logic contend;
  assign contend = bus.instr_req_i & bus.data_req_i;
`endif

  always_comb begin : arbitrate
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (RSTN) begin
`ifdef BOOT_ROM_ARB_RR_EN
      grant_instr = bus.instr_req_i & (~bus.data_req_i | (state_q.prio == PRIO_INSTR));
`else
      grant_instr = bus.instr_req_i;
`endif
      grant_data  = bus.data_req_i & ~grant_instr;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin : state_reg
    if (!RSTN) begin
      state_q <= '{valid: 1'b0, owner: OWNER_INSTR, err: 1'b0, prio: PRIO_INSTR};
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d       = state_q;
    state_d.valid = grant_instr | grant_data;
    state_d.owner = grant_data ? OWNER_DATA : OWNER_INSTR;
    state_d.err   = grant_data ? data_bad : (grant_instr & instr_bad);
`ifdef BOOT_ROM_ARB_RR_EN
    // Only a contested grant moves the pointer, so a lone requester never steals a turn.
    if (contend) begin
      state_d.prio = ~state_q.prio;
    end
`else
    state_d.prio = PRIO_INSTR;
`endif
  end

  always_comb begin : outputs
    bus.instr_gnt_o = grant_instr;
    bus.data_gnt_o  = grant_data;

    bus.rom_csn_o = 1'b1;
    bus.rom_a_o   = '0;
    if (grant_instr && !instr_bad) begin
      bus.rom_csn_o = 1'b0;
      bus.rom_a_o   = instr_word;
    end else if (grant_data && !data_bad) begin
      bus.rom_csn_o = 1'b0;
      bus.rom_a_o   = data_word;
    end

    // Errored accesses never touched the ROM, so rom_q_i is stale and must be masked.
    resp_rdata = state_q.err ? 32'h0 : bus.rom_q_i;

    bus.instr_rvalid_o = state_q.valid & (state_q.owner == OWNER_INSTR);
    bus.instr_rdata_o  = bus.instr_rvalid_o ? resp_rdata : 32'h0;
    bus.instr_err_o    = bus.instr_rvalid_o & state_q.err;

    bus.data_rvalid_o  = state_q.valid & (state_q.owner == OWNER_DATA);
    bus.data_rdata_o   = bus.data_rvalid_o ? resp_rdata : 32'h0;
    bus.data_err_o     = bus.data_rvalid_o & state_q.err;

    dbg_state = state_q;
  end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Self-checking bench for boot_rom_arbiter: directed vector table, reset sequence,
// then constrained-random traffic against a transaction-level reference model.
module tb_boot_rom_arbiter;

  localparam logic [31:0] BASE_ADDR = 32'h0000_8000;
  localparam int          ROM_WORDS = 548;
  localparam logic [31:0] ROM_BYTES = 32'd2192;
  localparam int          W         = 34;

  logic       CLK;
  logic       RSTN;
  logic [3:0] dbg_state;

  boot_rom_arbiter_if #(.ROM_AW(10)) bus ();

  boot_rom_arbiter #(
    .BASE_ADDR(BASE_ADDR),
    .ROM_WORDS(ROM_WORDS),
    .ROM_AW   (10)
  ) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ROM macro model: registers its address on a csn-low edge
  logic [31:0] rom_mem [0:ROM_WORDS-1];
  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) bus.rom_q_i <= 32'h0;
    else if (!bus.rom_csn_o) bus.rom_q_i <= rom_mem[bus.rom_a_o];
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_fail;
  int           cyc;
  logic         prio_m;
  logic         last_ig, last_dg;
  logic         d_ireq, d_dreq, d_dwe;
  logic [31:0]  d_iaddr, d_daddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: actual %h required %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] addr, input logic we);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (off >= ROM_BYTES) || ((addr % 4) != 0) || we;
  endfunction

  // Reference model: one response per grant, delivered the following cycle.
  task automatic check_cycle();
    logic [W-1:0] r;
    logic         has, ig, dg, bad, hit;
    logic [31:0]  gaddr, word;
    has = 1'b0;
    r   = '0;
    if (exp_q.size() != 0) begin
      r   = exp_q.pop_front();
      has = 1'b1;
    end
    if (!RSTN) has = 1'b0;
    chk("instr_rvalid", bus.instr_rvalid_o, has && !r[33]);
    chk("instr_rdata", bus.instr_rdata_o, (has && !r[33]) ? r[31:0] : 32'h0);
    chk("instr_err", bus.instr_err_o, has && !r[33] && r[32]);
    chk("data_rvalid", bus.data_rvalid_o, has && r[33]);
    chk("data_rdata", bus.data_rdata_o, (has && r[33]) ? r[31:0] : 32'h0);
    chk("data_err", bus.data_err_o, has && r[33] && r[32]);

    ig = 1'b0;
    dg = 1'b0;
    if (!RSTN) begin
      prio_m = 1'b0;
    end else if (d_ireq && d_dreq) begin
`ifdef BOOT_ROM_ARB_RR_EN
      dg     = prio_m;
      ig     = !prio_m;
      prio_m = !prio_m;
`else
      ig = 1'b1;
`endif
    end else begin
      ig = d_ireq;
      dg = d_dreq;
    end
    gaddr = dg ? d_daddr : d_iaddr;
    bad   = addr_bad(gaddr, dg && d_dwe);
    word  = (gaddr - BASE_ADDR) / 4;
    hit   = (ig || dg) && !bad;
    chk("instr_gnt", bus.instr_gnt_o, ig);
    chk("data_gnt", bus.data_gnt_o, dg);
    chk("rom_csn", bus.rom_csn_o, !hit);
    chk("rom_a", bus.rom_a_o, hit ? {22'h0, word[9:0]} : 32'h0);
    if (ig || dg) exp_q.push_back({dg, bad, hit ? rom_mem[word] : 32'h0});
    last_ig = ig;
    last_dg = dg;
    cyc++;
  endtask

  // driver: apply one cycle of inputs at the falling edge, then check
  task automatic step(input logic rst, input logic ireq, input logic [31:0] iaddr,
                      input logic dreq, input logic [31:0] daddr, input logic dwe);
    @(negedge CLK);
    RSTN    = rst;
    d_ireq  = ireq;
    d_iaddr = iaddr;
    d_dreq  = dreq;
    d_daddr = daddr;
    d_dwe   = dwe;
    bus.instr_req_i  = ireq;
    bus.instr_addr_i = iaddr;
    bus.data_req_i   = dreq;
    bus.data_addr_i  = daddr;
    bus.data_we_i    = dwe;
    #1;
    check_cycle();
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic        dwe;
    logic        e_ig;
    logic        e_dg;
    logic        e_csn;
    logic [9:0]  e_a;
    logic        e_irv;
    logic        e_drv;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  function automatic vec_t mkv(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic [31:0] daddr, input logic dwe,
                               input logic e_ig, input logic e_dg, input logic e_csn,
                               input logic [9:0] e_a, input logic e_irv, input logic e_drv,
                               input logic [31:0] e_rdata, input logic e_err);
    vec_t v;
    v.ireq = ireq;  v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr; v.dwe = dwe;
    v.e_ig = e_ig;  v.e_dg = e_dg;   v.e_csn = e_csn; v.e_a = e_a;
    v.e_irv = e_irv; v.e_drv = e_drv; v.e_rdata = e_rdata; v.e_err = e_err;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return BASE_ADDR + 4 * $urandom_range(0, ROM_WORDS - 1);
      6:                return BASE_ADDR + 4 * $urandom_range(0, ROM_WORDS - 1) + $urandom_range(1, 3);
      7:                return BASE_ADDR + ROM_BYTES + 4 * $urandom_range(0, 100);
      8:                return BASE_ADDR - 4 * $urandom_range(1, 8);
      default:          return $urandom();
    endcase
  endfunction

  vec_t vecs[$];

  initial begin
    logic        p_ireq, p_dreq, p_dwe;
    logic [31:0] p_iaddr, p_daddr;

    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    prio_m   = 1'b0;
    RSTN     = 1'b0;
    d_ireq = 0; d_dreq = 0; d_dwe = 0; d_iaddr = 0; d_daddr = 0;
    bus.instr_req_i = 0; bus.instr_addr_i = 0;
    bus.data_req_i = 0; bus.data_addr_i = 0; bus.data_we_i = 0;

    for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = $urandom();
    rom_mem[0]   = 32'h0000_0013;
    rom_mem[1]   = 32'h1111_1111;
    rom_mem[32]  = 32'h0100_006F;
    rom_mem[33]  = 32'h0100_006F;
    rom_mem[34]  = 32'h0080_006F;
    rom_mem[36]  = 32'h0000_0093;
    rom_mem[547] = 32'hDEAD_BEEF;

    // directed vectors: inputs for one cycle, expected outputs in that same cycle
    vecs.push_back(mkv(0, 0, 0, 0, 0,                          0, 0, 1, 0,   0, 0, 32'h0, 0));
    vecs.push_back(mkv(1, 32'h8000, 0, 0, 0,                   1, 0, 0, 0,   0, 0, 32'h0, 0));
    vecs.push_back(mkv(1, 32'h8080, 0, 0, 0,                   1, 0, 0, 32,  1, 0, 32'h0000_0013, 0));
    vecs.push_back(mkv(1, 32'h8084, 0, 0, 0,                   1, 0, 0, 33,  1, 0, 32'h0100_006F, 0));
    vecs.push_back(mkv(1, 32'h8088, 0, 0, 0,                   1, 0, 0, 34,  1, 0, 32'h0100_006F, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,                          0, 0, 1, 0,   1, 0, 32'h0080_006F, 0));
    vecs.push_back(mkv(0, 0, 1, 32'h8890, 0,                   0, 1, 1, 0,   0, 0, 32'h0, 0));
    vecs.push_back(mkv(0, 0, 1, 32'h8002, 0,                   0, 1, 1, 0,   0, 1, 32'h0, 1));
    vecs.push_back(mkv(0, 0, 1, 32'h8000, 1,                   0, 1, 1, 0,   0, 1, 32'h0, 1));
    vecs.push_back(mkv(0, 0, 1, 32'h7FFC, 0,                   0, 1, 1, 0,   0, 1, 32'h0, 1));
    vecs.push_back(mkv(0, 0, 1, 32'h888C, 0,                   0, 1, 0, 547, 0, 1, 32'h0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0,                          0, 0, 1, 0,   0, 1, 32'hDEAD_BEEF, 0));
`ifdef BOOT_ROM_ARB_RR_EN
    vecs.push_back(mkv(1, 32'h8000, 1, 32'h8004, 0,            1, 0, 0, 0,   0, 0, 32'h0, 0));
    vecs.push_back(mkv(1, 32'h8000, 1, 32'h8004, 0,            0, 1, 0, 1,   1, 0, 32'h0000_0013, 0));
    vecs.push_back(mkv(1, 32'h8000, 1, 32'h8004, 0,            1, 0, 0, 0,   0, 1, 32'h1111_1111, 0));
    vecs.push_back(mkv(1, 32'h8000, 1, 32'h8004, 0,            0, 1, 0, 1,   1, 0, 32'h0000_0013, 0));
    vecs.push_back(mkv(0, 0, 1, 32'h8004, 0,                   0, 1, 0, 1,   0, 1, 32'h1111_1111, 0));
`else
    vecs.push_back(mkv(1, 32'h8000, 1, 32'h8004, 0,            1, 0, 0, 0,   0, 0, 32'h0, 0));
    vecs.push_back(mkv(1, 32'h8000, 1, 32'h8004, 0,            1, 0, 0, 0,   1, 0, 32'h0000_0013, 0));
    vecs.push_back(mkv(1, 32'h8000, 1, 32'h8004, 0,            1, 0, 0, 0,   1, 0, 32'h0000_0013, 0));
    vecs.push_back(mkv(1, 32'h8000, 1, 32'h8004, 0,            1, 0, 0, 0,   1, 0, 32'h0000_0013, 0));
    vecs.push_back(mkv(0, 0, 1, 32'h8004, 0,                   0, 1, 0, 1,   1, 0, 32'h0000_0013, 0));
`endif
    vecs.push_back(mkv(0, 0, 0, 0, 0,                          0, 0, 1, 0,   0, 1, 32'h1111_1111, 0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mkv(0, 0, 0, 0, 0,                        0, 0, 1, 0,   0, 0, 32'h0, 0));

    // reset values, with a request present to show gnt is held low
    step(0, 1, 32'h8000, 1, 32'h8004, 0);
    chk("rst_dbg_state", dbg_state, 4'h0);
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(1, vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].daddr, vecs[i].dwe);
      chk($sformatf("v%0d instr_gnt", i), bus.instr_gnt_o, vecs[i].e_ig);
      chk($sformatf("v%0d data_gnt", i), bus.data_gnt_o, vecs[i].e_dg);
      chk($sformatf("v%0d rom_csn", i), bus.rom_csn_o, vecs[i].e_csn);
      chk($sformatf("v%0d rom_a", i), bus.rom_a_o, vecs[i].e_a);
      chk($sformatf("v%0d instr_rvalid", i), bus.instr_rvalid_o, vecs[i].e_irv);
      chk($sformatf("v%0d data_rvalid", i), bus.data_rvalid_o, vecs[i].e_drv);
      chk($sformatf("v%0d instr_rdata", i), bus.instr_rdata_o, vecs[i].e_irv ? vecs[i].e_rdata : 32'h0);
      chk($sformatf("v%0d data_rdata", i), bus.data_rdata_o, vecs[i].e_drv ? vecs[i].e_rdata : 32'h0);
      chk($sformatf("v%0d instr_err", i), bus.instr_err_o, vecs[i].e_irv && vecs[i].e_err);
      chk($sformatf("v%0d data_err", i), bus.data_err_o, vecs[i].e_drv && vecs[i].e_err);
    end

    // reset in the cycle after a grant: the pending response is dropped
    step(1, 1, 32'h8000, 0, 0, 0);
    chk("mid_rst_grant", bus.instr_gnt_o, 1'b1);
    step(0, 1, 32'h8004, 1, 32'h8008, 0);
    chk("mid_rst_rvalid", bus.instr_rvalid_o, 1'b0);
    chk("mid_rst_csn", bus.rom_csn_o, 1'b1);
    chk("mid_rst_gnt", bus.data_gnt_o, 1'b0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("post_rst_rvalid", bus.instr_rvalid_o, 1'b0);
    step(1, 1, 32'h8090, 0, 0, 0);
    chk("post_rst_a", bus.rom_a_o, 10'd36);
    step(1, 0, 0, 0, 0, 0);
    chk("post_rst_rdata", bus.instr_rdata_o, 32'h0000_0093);
    chk("post_rst_rv", bus.instr_rvalid_o, 1'b1);

    // constrained-random traffic; a requester holds req/addr until granted
    p_ireq = 0; p_dreq = 0; p_dwe = 0; p_iaddr = 0; p_daddr = 0;
    for (int c = 0; c < 600; c++) begin
      if (!p_ireq) begin
        p_ireq  = ($urandom_range(0, 99) < 60);
        p_iaddr = rand_addr();
      end
      if (!p_dreq) begin
        p_dreq  = ($urandom_range(0, 99) < 50);
        p_daddr = rand_addr();
        p_dwe   = ($urandom_range(0, 7) == 0);
      end
      if (c % 200 == 199) begin
        step(0, p_ireq, p_iaddr, p_dreq, p_daddr, p_dreq && p_dwe);
        p_ireq = 0;
        p_dreq = 0;
      end else begin
        step(1, p_ireq, p_iaddr, p_dreq, p_daddr, p_dreq && p_dwe);
        if (last_ig) p_ireq = 0;
        else if (p_ireq && $urandom_range(0, 19) == 0) p_ireq = 0;
        if (last_dg) p_dreq = 0;
        else if (p_dreq && $urandom_range(0, 19) == 0) p_dreq = 0;
      end
    end
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
